// File: rtl/dram_wr_queue_if.sv
// Write-beat and memory-command signals shared by the packer, the write queue and the controller.
// master is the packer/controller side; slave is the queue.
interface dram_wr_queue_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  dram_ready;
    logic                  wr_pending;
    logic                  mem_cmd_valid;
    logic                  mem_cmd_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ack;
    logic                  overflow;
    logic                  ack_err;

    modport master (
        output wr_en, wr_addr, wr_data, mem_cmd_ready, mem_ack,
        input  dram_ready, wr_pending, mem_cmd_valid, mem_addr, mem_data, overflow, ack_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, mem_cmd_ready, mem_ack,
        output dram_ready, wr_pending, mem_cmd_valid, mem_addr, mem_data, overflow, ack_err
    );
endinterface

// File: rtl/dram_wr_queue.sv
// DRAM write-command queue: buffers packer beats in a FIFO and issues them to the
// memory controller, capping the number of issued-but-unacknowledged writes.
module dram_wr_queue #(
    parameter int ADDR_WIDTH      = 15,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 16,
    parameter int AF_MARGIN       = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic           dram_clk,
    input  logic           dram_rst,
    dram_wr_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(DEPTH - AF_MARGIN);
    localparam logic [OW-1:0] OUT_LIMIT = OW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {IDLE, ISSUE, THROTTLE} state_t;

    beat_t         fifo [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [OW-1:0] outstanding, outstanding_nxt;
    state_t        state, state_nxt;
    beat_t         cmd;
    logic          cmd_valid, cmd_valid_nxt;
    logic          ready_q, pending_q, overflow_q, ack_err_q;
    logic          hs, ack_ok, load, push;

    assign hs     = cmd_valid && bus.mem_cmd_ready;
    assign ack_ok = bus.mem_ack && (outstanding != '0 || hs);
    // A load in the same cycle frees the head slot, so a beat arriving at full is still taken.
    assign push   = bus.wr_en && (count != FULL_CNT || load);
    assign cmd_valid_nxt = load ? 1'b1 : (hs ? 1'b0 : cmd_valid);

    always_comb begin
        outstanding_nxt = outstanding;
        if (hs && !ack_ok)
            outstanding_nxt = outstanding + 1'b1;
        else if (!hs && ack_ok)
            outstanding_nxt = outstanding - 1'b1;
    end

    always_comb begin
        count_nxt = count;
        if (push && !load)
            count_nxt = count + 1'b1;
        else if (!push && load)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && outstanding < OUT_LIMIT) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Back-to-back issue uses the outstanding count as it will be after this edge.
                if (hs) begin
                    if (count != '0 && outstanding_nxt < OUT_LIMIT)
                        load = 1'b1;
                    else if (count != '0)
                        state_nxt = THROTTLE;
                    else
                        state_nxt = IDLE;
                end
            end
            THROTTLE: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                end else if (outstanding < OUT_LIMIT) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge dram_clk)
        if (push)
            fifo[wr_ptr] <= {bus.wr_addr, bus.wr_data};

    always_ff @(posedge dram_clk or posedge dram_rst) begin
        if (dram_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            ready_q     <= 1'b1;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            ack_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            outstanding <= outstanding_nxt;
            cmd_valid   <= cmd_valid_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
                cmd    <= fifo[rd_ptr];
            end
            ready_q   <= count_nxt < AF_CNT;
            pending_q <= count_nxt != '0 || cmd_valid_nxt || outstanding_nxt != '0;
            if (bus.wr_en && !push)
                overflow_q <= 1'b1;
            if (bus.mem_ack && !ack_ok)
                ack_err_q <= 1'b1;
        end
    end

    assign bus.mem_cmd_valid = cmd_valid;
    assign bus.mem_addr      = cmd.addr;
    assign bus.mem_data      = cmd.data;
    assign bus.dram_ready    = ready_q;
    assign bus.wr_pending    = pending_q;
    assign bus.overflow      = overflow_q;
    assign bus.ack_err       = ack_err_q;
endmodule

// File: tb/tb_dram_wr_queue.sv
// Bench for dram_wr_queue: directed latency/throttle/reset cases, then a randomized run
// against a queue-based reference of accepted, issued and acknowledged writes.
module tb_dram_wr_queue;
    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    int               nhs, accepted, acked, mout, fcnt;
    int               wr_pct, rdy_pct, ack_pct;
    logic             prev_stall;
    logic [AW+DW-1:0] prev_cmd;

    dram_wr_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    dram_wr_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .AF_MARGIN(2), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .dram_clk(clk),
        .dram_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.wr_en         = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.mem_cmd_ready = 1'b0;
        bus.mem_ack       = 1'b0;
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    // Current command must match the oldest expected beat.
    task automatic take(input string tag);
        logic [AW+DW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_extra"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {bus.mem_addr, bus.mem_data}, e);
        end
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", bus.mem_cmd_valid, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_ready", bus.dram_ready, 1);
        chk("rst_pending", bus.wr_pending, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_ackerr", bus.ack_err, 0);
        rst = 1'b0;
        cyc();

        // single write, N+2 latency, pending clears the cycle after the ack
        beat(15'h0010, 32'hDEADBEEF);
        bus.mem_cmd_ready = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        chk("t1_valid_n1", bus.mem_cmd_valid, 0);
        chk("t1_pend_n1", bus.wr_pending, 1);
        cyc();
        chk("t1_valid_n2", bus.mem_cmd_valid, 1);
        chk("t1_addr", bus.mem_addr, 15'h0010);
        chk("t1_data", bus.mem_data, 32'hDEADBEEF);
        cyc();
        chk("t1_valid_n3", bus.mem_cmd_valid, 0);
        cyc();
        chk("t1_pend_n4", bus.wr_pending, 1);
        cyc();
        bus.mem_ack = 1'b1;
        chk("t1_pend_ack", bus.wr_pending, 1);
        cyc();
        bus.mem_ack = 1'b0;
        chk("t1_pend_clr", bus.wr_pending, 0);
        bus.mem_cmd_ready = 1'b0;

        // burst with controller stalled; first beat sits in the output register
        for (int k = 1; k <= 18; k++) begin
            beat(AW'(32'h100 + k), 32'hA500_0000 | k);
            if (k <= 17)
                exp_q.push_back({bus.wr_addr, bus.wr_data});
            cyc();
            fcnt = (k == 1) ? 1 : ((k - 1 > 16) ? 16 : k - 1);
            chk("t2_ready", bus.dram_ready, fcnt < 14);
            chk("t2_ovf", bus.overflow, k == 18);
        end
        bus.wr_en = 1'b0;

        // release with no acks: only MAXO issue, then one issue per ack
        bus.mem_cmd_ready = 1'b1;
        nhs = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_cmd_valid) begin
                nhs++;
                take("t3_order");
            end
            cyc();
        end
        chk("t3_hs_limit", nhs, MAXO);
        chk("t3_throttled", bus.mem_cmd_valid, 0);
        for (int a = 0; a < 9; a++) begin
            bus.mem_ack = 1'b1;
            cyc();
            bus.mem_ack = 1'b0;
            nhs = 0;
            for (int i = 0; i < 6; i++) begin
                if (bus.mem_cmd_valid) begin
                    nhs++;
                    take("t3_order_ack");
                end
                cyc();
            end
            chk("t3_one_per_ack", nhs, 1);
        end
        chk("t3_all_issued", exp_q.size(), 0);

        // outstanding at the limit: ack+handshake together keeps the next issue flowing
        bus.mem_cmd_ready = 1'b0;
        beat(15'h07A0, 32'h1111_1111);
        cyc();
        beat(15'h07B0, 32'h2222_2222);
        cyc();
        bus.wr_en = 1'b0;
        cyc();
        cyc();
        chk("t4_hold", bus.mem_cmd_valid, 0);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5 && !bus.mem_cmd_valid; i++)
            cyc();
        chk("t4_a_valid", bus.mem_cmd_valid, 1);
        chk("t4_a_addr", bus.mem_addr, 15'h07A0);
        bus.mem_cmd_ready = 1'b1;
        bus.mem_ack       = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("t4_b_valid", bus.mem_cmd_valid, 1);
        chk("t4_b_addr", bus.mem_addr, 15'h07B0);
        chk("t4_b_data", bus.mem_data, 32'h2222_2222);
        cyc();
        bus.mem_cmd_ready = 1'b0;
        chk("t4_b_done", bus.mem_cmd_valid, 0);
        chk("t4_no_err", bus.ack_err, 0);
        bus.mem_ack = 1'b1;
        repeat (8) cyc();
        bus.mem_ack = 1'b0;
        chk("t4_pend_clr", bus.wr_pending, 0);
        chk("t4_no_err2", bus.ack_err, 0);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("t4_ack_err", bus.ack_err, 1);

        // reset mid-burst with count=5, outstanding=3, command valid
        for (int k = 1; k <= 9; k++) begin
            beat(AW'(32'h200 + k), 32'hC000_0000 | k);
            cyc();
        end
        bus.wr_en = 1'b0;
        bus.mem_cmd_ready = 1'b1;
        repeat (3) cyc();
        bus.mem_cmd_ready = 1'b0;
        chk("t5_pre_valid", bus.mem_cmd_valid, 1);
        chk("t5_pre_addr", bus.mem_addr, 15'h0204);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_valid", bus.mem_cmd_valid, 0);
        chk("t5_ready", bus.dram_ready, 1);
        chk("t5_pending", bus.wr_pending, 0);
        chk("t5_ackerr", bus.ack_err, 0);
        chk("t5_addr", bus.mem_addr, 0);
        cyc();
        rst = 1'b0;
        beat(15'h0ABC, 32'h1234_5678);
        bus.mem_cmd_ready = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        chk("t5_post_n1", bus.mem_cmd_valid, 0);
        cyc();
        chk("t5_post_valid", bus.mem_cmd_valid, 1);
        chk("t5_post_addr", bus.mem_addr, 15'h0ABC);
        chk("t5_post_data", bus.mem_data, 32'h1234_5678);
        cyc();
        chk("t5_post_done", bus.mem_cmd_valid, 0);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("t5_post_pend", bus.wr_pending, 0);

        // randomized traffic against the reference queue
        idle_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        accepted   = 0;
        acked      = 0;
        mout       = 0;
        prev_stall = 1'b0;
        prev_cmd   = '0;
        wr_pct = 50; rdy_pct = 50; ack_pct = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 1000 == 0) begin
                wr_pct  = $urandom_range(10, 90);
                rdy_pct = $urandom_range(10, 90);
                ack_pct = $urandom_range(10, 90);
            end
            if (prev_stall) begin
                chk("r_hold_valid", bus.mem_cmd_valid, 1);
                chk("r_hold_cmd", {bus.mem_addr, bus.mem_data}, prev_cmd);
            end
            chk("r_pending", bus.wr_pending, (accepted - acked) != 0);
            chk("r_limit", bus.mem_cmd_valid && mout >= MAXO, 0);
            bus.wr_en         = bus.dram_ready && ($urandom_range(0, 99) < wr_pct);
            bus.wr_addr       = AW'($urandom);
            bus.wr_data       = $urandom;
            bus.mem_cmd_ready = $urandom_range(0, 99) < rdy_pct;
            bus.mem_ack       = (mout > 0) && ($urandom_range(0, 99) < ack_pct);
            if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                take("r_order");
                mout++;
            end
            if (bus.wr_en) begin
                exp_q.push_back({bus.wr_addr, bus.wr_data});
                accepted++;
            end
            if (bus.mem_ack) begin
                mout--;
                acked++;
            end
            prev_stall = bus.mem_cmd_valid && !bus.mem_cmd_ready;
            prev_cmd   = {bus.mem_addr, bus.mem_data};
            cyc();
        end

        // drain everything still queued or in flight
        bus.wr_en = 1'b0;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || mout != 0); i++) begin
            bus.mem_cmd_ready = 1'b1;
            bus.mem_ack       = mout > 0;
            if (bus.mem_cmd_valid) begin
                take("d_order");
                mout++;
            end
            if (bus.mem_ack) begin
                mout--;
                acked++;
            end
            cyc();
        end
        bus.mem_ack       = 1'b0;
        bus.mem_cmd_ready = 1'b0;
        chk("d_empty", exp_q.size(), 0);
        chk("d_outstanding", mout, 0);
        chk("d_pending", bus.wr_pending, 0);
        chk("d_valid", bus.mem_cmd_valid, 0);
        chk("d_ovf", bus.overflow, 0);
        chk("d_ackerr", bus.ack_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
